// File: rtl/edge_window_stream.sv
// Streaming 3x3 edge filter: two line buffers, a 3x3 window and a
// two-stage arithmetic pipeline selecting Laplacian, |Laplacian|, Sobel or pass.
module edge_window_stream #(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic [DW-1:0] i_data,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] thr,
  output logic          o_valid,
  output logic          o_sof,
  output logic [DW-1:0] o_data
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int IW = DW + 5;
  localparam logic signed [IW-1:0] MAXV = {5'b0, {DW{1'b1}}};

  typedef enum logic [0:0] {
    IDLE,
    ACTIVE
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  col, col_n, pcol;
  logic [RW-1:0]  row, row_n, prow;
  logic [1:0]     mode_q, mode_n;
  logic [DW-1:0]  thr_q, thr_n;
  logic           acc, emit, first;

  logic [DW-1:0]  lb0 [IMG_W];
  logic [DW-1:0]  lb1 [IMG_W];
  logic [DW-1:0]  lb0_out, lb1_out;
  logic [DW-1:0]  w [3][3];

  logic           s0_v, s0_sof;
  logic [1:0]     s0_mode;
  logic [DW-1:0]  s0_thr;

  logic signed [IW-1:0] x00, x01, x02;
  logic signed [IW-1:0] x10, x11, x12;
  logic signed [IW-1:0] x20, x21, x22;
  logic signed [IW-1:0] lap_c, gx_c, gy_c;

  logic                 s1_v, s1_sof;
  logic [1:0]           s1_mode;
  logic [DW-1:0]        s1_thr, s1_c;
  logic signed [IW-1:0] s1_lap, s1_gx, s1_gy;

  logic signed [IW-1:0] ax, ay, al, res;
  logic [DW-1:0]        sat, out_d;

  function automatic logic signed [IW-1:0] zx(input logic [DW-1:0] v);
    return $signed({5'b0, v});
  endfunction

  // Frame position tracking; a sof pixel always lands at (0,0)
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    mode_n  = mode_q;
    thr_n   = thr_q;
    acc     = 1'b0;
    prow    = row;
    pcol    = col;
    if (i_valid && i_sof) begin
      acc    = 1'b1;
      prow   = '0;
      pcol   = '0;
      mode_n = mode;
      thr_n  = thr;
    end else if (i_valid && state == ACTIVE) begin
      acc = 1'b1;
    end
    if (acc) begin
      state_n = ACTIVE;
      if (pcol == CW'(IMG_W - 1)) begin
        col_n = '0;
        row_n = prow + RW'(1);
        if (prow == RW'(IMG_H - 1)) begin
          state_n = IDLE;
          row_n   = '0;
        end
      end else begin
        col_n = pcol + CW'(1);
        row_n = prow;
      end
    end
    emit  = acc && (prow >= RW'(2)) && (pcol >= CW'(2));
    first = emit && (prow == RW'(2)) && (pcol == CW'(2));
  end

  // State, counters and latched per-frame configuration
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      mode_q <= '0;
      thr_q  <= '0;
    end else begin
      state  <= state_n;
      row    <= row_n;
      col    <= col_n;
      mode_q <= mode_n;
      thr_q  <= thr_n;
    end
  end

  assign lb0_out = lb0[pcol];
  assign lb1_out = lb1[pcol];

  // Line buffers: lb0 holds the previous line, lb1 the one before it
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[pcol] <= i_data;
      lb1[pcol] <= lb0_out;
    end
  end

  // Window shifts left on each accepted pixel, new column enters at c2
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else if (acc) begin
      for (int r = 0; r < 3; r++) begin
        w[r][0] <= w[r][1];
        w[r][1] <= w[r][2];
      end
      w[0][2] <= lb1_out;
      w[1][2] <= lb0_out;
      w[2][2] <= i_data;
    end
  end

  // Tags travelling alongside the window contents
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_v    <= 1'b0;
      s0_sof  <= 1'b0;
      s0_mode <= '0;
      s0_thr  <= '0;
    end else begin
      s0_v    <= emit;
      s0_sof  <= first;
      s0_mode <= mode_n;
      s0_thr  <= thr_n;
    end
  end

  // Stage 1 operands and sums
  always_comb begin
    x00   = zx(w[0][0]);
    x01   = zx(w[0][1]);
    x02   = zx(w[0][2]);
    x10   = zx(w[1][0]);
    x11   = zx(w[1][1]);
    x12   = zx(w[1][2]);
    x20   = zx(w[2][0]);
    x21   = zx(w[2][1]);
    x22   = zx(w[2][2]);
    lap_c = x00 + x01 + x02 + x10 + x12 + x20 + x21 + x22
          - (x11 <<< 3);
    gx_c  = (x02 + (x12 <<< 1) + x22)
          - (x00 + (x10 <<< 1) + x20);
    gy_c  = (x20 + (x21 <<< 1) + x22)
          - (x00 + (x01 <<< 1) + x02);
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v    <= 1'b0;
      s1_sof  <= 1'b0;
      s1_mode <= '0;
      s1_thr  <= '0;
      s1_c    <= '0;
      s1_lap  <= '0;
      s1_gx   <= '0;
      s1_gy   <= '0;
    end else begin
      s1_v    <= s0_v;
      s1_sof  <= s0_sof;
      s1_mode <= s0_mode;
      s1_thr  <= s0_thr;
      s1_c    <= w[1][1];
      s1_lap  <= lap_c;
      s1_gx   <= gx_c;
      s1_gy   <= gy_c;
    end
  end

  // Stage 2: operator select, saturate, threshold
  always_comb begin
    ax = s1_gx[IW-1] ? -s1_gx : s1_gx;
    ay = s1_gy[IW-1] ? -s1_gy : s1_gy;
    al = s1_lap[IW-1] ? -s1_lap : s1_lap;
    res = '0;
    unique case (s1_mode)
      2'd0:    res = s1_lap[IW-1] ? '0 : s1_lap;
      2'd1:    res = al;
      2'd2:    res = ax + ay;
      default: res = zx(s1_c);
    endcase
    sat   = (res > MAXV) ? {DW{1'b1}} : res[DW-1:0];
    out_d = (sat < s1_thr) ? '0 : sat;
  end

  // Output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= s1_v;
      o_sof   <= s1_v & s1_sof;
      o_data  <= s1_v ? out_d : '0;
    end
  end

endmodule

// File: tb/tb_edge_window_stream.sv
// Directed bench for edge_window_stream on an 8x6 frame.
// Expected values derive from the pattern geometry by hand.
module tb_edge_window_stream;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_valid, i_sof;
  logic [7:0] i_data;
  logic [1:0] mode;
  logic [7:0] thr;
  logic       o_valid, o_sof;
  logic [7:0] o_data;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int drv_cyc, c22;

  logic [7:0] oq[$];
  logic       sq[$];
  int         cq[$];

  edge_window_stream #(
    .DW(8), .IMG_W(8), .IMG_H(6)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
    .mode(mode), .thr(thr),
    .o_valid(o_valid), .o_sof(o_sof), .o_data(o_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && o_valid) begin
      oq.push_back(o_data);
      sq.push_back(o_sof);
      cq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic px(input logic [7:0] d, input logic s);
    @(negedge clk);
    i_valid = 1'b1;
    i_sof   = s;
    i_data  = d;
    drv_cyc = cyc;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_sof   = 1'b0;
    end
  endtask

  function automatic logic [7:0] pix(input int k, input int r, input int c);
    case (k)
      0:       return 8'd100;
      1:       return (r == 3 && c == 3) ? 8'd200 : 8'd0;
      default: return (c >= 4) ? 8'd50 : 8'd0;
    endcase
  endfunction

  // e: 0 all zero, 1 spike lap-clamp, 2 spike lap-abs,
  //    3 sobel step, 5 flat pass = 100
  function automatic int exp_val(input int e, input int r, input int c);
    bit ctr, nbr;
    ctr = (r == 3 && c == 3);
    nbr = !ctr && (r >= 2 && r <= 4 && c >= 2 && c <= 4);
    case (e)
      1:       return nbr ? 200 : 0;
      2:       return ctr ? 255 : (nbr ? 200 : 0);
      3:       return (c == 3 || c == 4) ? 200 : 0;
      5:       return 100;
      default: return 0;
    endcase
  endfunction

  task automatic send_frame(input int k, input int nrows,
                            input bit gaps, input int chg_row);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (r == chg_row && c == 0) begin
          mode = 2'd1;
          thr  = 8'd255;
        end
        px(pix(k, r, c), (r == 0 && c == 0));
        if (r == 2 && c == 2) c22 = drv_cyc;
        if (gaps) gap($urandom_range(0, 3));
      end
    end
    gap(1);
  endtask

  task automatic check_vals(input string nm, input int e,
                            input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < oq.size())
        chk($sformatf("%s[%0d]", nm, i), oq[base+i],
            exp_val(e, i / 6 + 1, i % 6 + 1));
    end
  endtask

  function automatic int sof_count();
    int n = 0;
    foreach (sq[i]) if (sq[i]) n++;
    return n;
  endfunction

  task automatic full_check(input string nm, input int e);
    chk({nm, "_cnt"}, oq.size(), 24);
    check_vals(nm, e, 0, 24);
    chk({nm, "_nsof"}, sof_count(), 1);
    if (sq.size() > 0) chk({nm, "_sof0"}, sq[0], 1);
  endtask

  task automatic run(input int k, input logic [1:0] m,
                     input logic [7:0] t, input bit gaps);
    mode = m;
    thr  = t;
    oq.delete(); sq.delete(); cq.delete();
    send_frame(k, 6, gaps, -1);
    gap(6);
  endtask

  initial begin
    rstn = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
    i_data = '0; mode = '0; thr = '0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_sof", o_sof, 0);
    chk("rst_data", o_data, 0);
    @(negedge clk); rstn = 1'b1;
    gap(2);

    run(0, 2'd0, 8'd0, 1'b0);
    full_check("t1", 0);
    if (cq.size() > 0) chk("t1_lat", cq[0] - c22, 3);

    run(1, 2'd0, 8'd0, 1'b0);
    full_check("t2_m0", 1);
    run(1, 2'd1, 8'd0, 1'b0);
    full_check("t2_m1", 2);

    run(2, 2'd2, 8'd0, 1'b0);
    full_check("t3", 3);
    run(2, 2'd2, 8'd201, 1'b0);
    full_check("t3_thr201", 0);
    run(2, 2'd2, 8'd200, 1'b0);
    full_check("t3_thr200", 3);

    mode = 2'd0; thr = 8'd0;
    oq.delete(); sq.delete(); cq.delete();
    send_frame(0, 6, 1'b1, -1);
    for (int i = 0; i < 5; i++) px(8'd77, 1'b0);
    gap(8);
    full_check("t4_flat", 0);
    run(1, 2'd1, 8'd0, 1'b1);
    full_check("t4_spk", 2);

    mode = 2'd0; thr = 8'd0;
    oq.delete(); sq.delete(); cq.delete();
    send_frame(1, 6, 1'b0, 1);
    gap(6);
    full_check("t5_chg", 1);

    mode = 2'd3; thr = 8'd0;
    oq.delete(); sq.delete(); cq.delete();
    send_frame(0, 4, 1'b0, -1);
    mode = 2'd1;
    send_frame(1, 6, 1'b0, -1);
    gap(6);
    chk("t5_rs_cnt", oq.size(), 36);
    check_vals("t5_part", 5, 0, 12);
    check_vals("t5_new", 2, 12, 24);
    chk("t5_nsof", sof_count(), 2);
    if (sq.size() > 12) chk("t5_sof12", sq[12], 1);
    if (cq.size() > 12) chk("t5_lat", cq[12] - c22, 3);

    mode = 2'd3; thr = 8'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        if (r == 3 && c == 4) break;
        px(8'd100, (r == 0 && c == 0));
      end
    gap(2);
    chk("t6_pre_v", o_valid, 1);
    chk("t6_pre_d", o_data, 100);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_v", o_valid, 0);
    chk("t6_rst_s", o_sof, 0);
    chk("t6_rst_d", o_data, 0);
    gap(2);
    rstn = 1'b1;
    oq.delete(); sq.delete(); cq.delete();
    for (int i = 0; i < 10; i++) px(8'd100, 1'b0);
    gap(8);
    chk("t6_ignored", oq.size(), 0);
    run(0, 2'd0, 8'd0, 1'b0);
    full_check("t6_clean", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
